regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised successor to the coprocessor register file. Provides a configurable number of combinational read ports and two write ports: a single-cycle execute port and a long-latency writeback port for multi-cycle crypto units. An integrated scoreboard lets the issue stage reserve a destination register; the reservation clears when the writeback arrives. Optional write-to-read bypass and hardwired zero register are included. Sits between the decode/issue stage and the execute and crypto-unit writeback paths.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_READ, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
write_enable  in  1  execute-port write strobe
write_addr  in  ADDR_W  execute-port address
write_data  in  DATA_W  execute-port data
wb_enable  in  1  long-latency writeback strobe
wb_addr  in  ADDR_W  writeback address
wb_data  in  DATA_W  writeback data
rsv_enable  in  1  reserve request for a destination register
rsv_addr  in  ADDR_W  register to reserve
rsv_ready  out  1  reservation would be accepted this cycle (combinational)
read_addr  in  NUM_READ*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W]
read_data  out  NUM_READ*DATA_W  packed read data
read_busy  out  NUM_READ  per-port: addressed register has a pending writeback
busy_vec  out  2**ADDR_W  scoreboard state
err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async, rst=1): all registers = 0, busy_vec = 0, err = 0. A reset asserted mid-operation discards pending reservations immediately; writebacks after reset are handled as writes to non-busy registers (see err rules).
- Reads: combinational. read_data[i] = regs[read_addr[i]] and read_busy[i] = busy[read_addr[i]], subject to the bypass and zero rules below.
- Writes commit on the rising clk edge; new value is visible on reads the cycle after the edge.
- BYPASS=1:
  - A read matching a same-cycle enabled write returns the write data.
  - If both write ports target the same address, the priority rule below applies to the bypassed data.
  - A read matching an enabled wb_addr also shows read_busy[i] = 0.
- BYPASS=0: reads return pre-edge contents and busy.
- ZERO_REG=1, address 0:
  - Reads return 0 with busy 0.
  - Writes are dropped.
  - A reservation is accepted (rsv_ready=1) but does not set busy.
  - No err is raised for address 0.
- Execute-port write to a busy register: the write is dropped and err is set. This is a WAW hazard the issue stage must prevent.
- Writeback to address A: regs[A] = wb_data and busy[A] cleared. If busy[A] was 0, the write is still performed and err is set.
- Simultaneous execute write and writeback to the same address: the writeback commits and err is set (the execute write targets a busy register, or this is a double write).
- Reservation handshake:
  - rsv_ready = !busy[rsv_addr] | (wb_enable & wb_addr == rsv_addr).
  - On rsv_enable & rsv_ready, busy[rsv_addr] = 1 at the edge.
  - Reservation and writeback to the same address in the same cycle: writeback data commits and busy ends at 1 (new pending owner).
  - rsv_enable & !rsv_ready has no effect and does not set err; issue must stall.
- err is sticky; only rst clears it.
- Width: no arithmetic; all addresses are compared at the full ADDR_W width.

Test Plan:
- Reset: pulse rst asynchronously (mid-clock) -> all read_data 0, busy_vec 0, err 0 without waiting for a clock edge.
- Basic write/read: write_enable=1, addr 15, data 15 -> with BYPASS=1, read port 0 at addr 15 shows 15 in the same cycle; with BYPASS=0, it shows 15 only after the edge.
- Zero register: write 123 to addr 0, then read addr 0 -> 0. Reserve addr 0 -> rsv_ready=1, busy_vec[0] stays 0, err 0.
- Scoreboard:
  - Reserve addr 3 -> busy_vec[3]=1 next cycle; read_busy=1 on any port reading addr 3; a second reserve of addr 3 gives rsv_ready=0.
  - Writeback addr 3 with 0xDEADBEEF -> busy clears, data reads 0xDEADBEEF, err 0.
- Hazards:
  - Execute write to busy addr 3 -> data unchanged, err=1 and held until rst.
  - Writeback to non-busy addr 7 -> data written, err=1.
- Simultaneous reserve and writeback on addr 5 (busy) -> rsv_ready=1, wb_data stored, busy_vec[5]=1 after the edge. Repeat with NUM_READ=4 and all four ports reading addr 5.

Source files
------------

// File: rtl/regfile_sb.sv
// Parametrised register file with two write ports (execute and long-latency
// writeback), a destination-reservation scoreboard and optional bypass/zero register.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         write_enable,
  input  logic [ADDR_W-1:0]            write_addr,
  input  logic [DATA_W-1:0]            write_data,
  input  logic                         wb_enable,
  input  logic [ADDR_W-1:0]            wb_addr,
  input  logic [DATA_W-1:0]            wb_data,
  input  logic                         rsv_enable,
  input  logic [ADDR_W-1:0]            rsv_addr,
  output logic                         rsv_ready,
  input  logic [NUM_READ*ADDR_W-1:0]   read_addr,
  output logic [NUM_READ*DATA_W-1:0]   read_data,
  output logic [NUM_READ-1:0]          read_busy,
  output logic [(2**ADDR_W)-1:0]       busy_vec,
  output logic                         err
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic              r_err;

  logic              w_wb_en;
  logic              w_ex_req;
  logic              w_ex_hit_wb;
  logic              w_ex_en;
  logic              w_rsv_ready;
  logic              w_rsv_set;
  logic              w_err_set;
  logic [DEPTH-1:0]  w_busy_nxt;

  // Writes to the hardwired zero register are filtered out before any hazard logic.
  assign w_wb_en     = wb_enable && !((ZERO_REG != 0) && (wb_addr == '0));
  assign w_ex_req    = write_enable && !((ZERO_REG != 0) && (write_addr == '0));
  assign w_ex_hit_wb = wb_enable && (wb_addr == write_addr);
  assign w_ex_en     = w_ex_req && !r_busy[write_addr] && !w_ex_hit_wb;

  assign w_rsv_ready = !r_busy[rsv_addr] || (wb_enable && (wb_addr == rsv_addr));
  assign w_rsv_set   = rsv_enable && w_rsv_ready && !((ZERO_REG != 0) && (rsv_addr == '0));

  assign w_err_set = (w_wb_en && !r_busy[wb_addr]) ||
                     (w_ex_req && (r_busy[write_addr] || w_ex_hit_wb));

  // Reservation is applied after the writeback clear so it becomes the new owner.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wb_en)   w_busy_nxt[wb_addr]  = 1'b0;
    if (w_rsv_set) w_busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_regs[k] <= '0;
    end else begin
      if (w_ex_en) r_regs[write_addr] <= write_data;
      if (w_wb_en) r_regs[wb_addr]    <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_rd;
      logic              w_rb;

      assign w_ra = read_addr[gi*ADDR_W +: ADDR_W];

      // Writeback forwarding overrides execute forwarding when both hit.
      always_comb begin
        w_rd = r_regs[w_ra];
        w_rb = r_busy[w_ra];
        if (BYPASS != 0) begin
          if (w_ex_en && (write_addr == w_ra)) w_rd = write_data;
          if (w_wb_en && (wb_addr == w_ra))    w_rd = wb_data;
          if (wb_enable && (wb_addr == w_ra))  w_rb = 1'b0;
        end
        if ((ZERO_REG != 0) && (w_ra == '0)) begin
          w_rd = '0;
          w_rb = 1'b0;
        end
      end

      assign read_data[gi*DATA_W +: DATA_W] = w_rd;
      assign read_busy[gi]                  = w_rb;
    end
  endgenerate

  assign rsv_ready = w_rsv_ready;
  assign busy_vec  = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a reference model predicts outputs per cycle,
// a monitor compares them on the falling edge.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int D  = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             write_enable = 1'b0;
  logic [AW-1:0]    write_addr = '0;
  logic [DW-1:0]    write_data = '0;
  logic             wb_enable = 1'b0;
  logic [AW-1:0]    wb_addr = '0;
  logic [DW-1:0]    wb_data = '0;
  logic             rsv_enable = 1'b0;
  logic [AW-1:0]    rsv_addr = '0;
  logic             rsv_ready;
  logic [NR*AW-1:0] read_addr = '0;
  logic [NR*DW-1:0] read_data;
  logic [NR-1:0]    read_busy;
  logic [D-1:0]     busy_vec;
  logic             err;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsv_enable(rsv_enable), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .read_addr(read_addr), .read_data(read_data), .read_busy(read_busy),
    .busy_vec(busy_vec), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rb;
    logic             rr;
    logic [D-1:0]     bv;
    logic             er;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Architectural state of the reference model
  logic [DW-1:0] m_regs [D];
  logic          m_busy [D];
  logic          m_err;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("read_data", 128'(read_data), 128'(e.rd));
        chk("read_busy", 128'(read_busy), 128'(e.rb));
        chk("rsv_ready", 128'(rsv_ready), 128'(e.rr));
        chk("busy_vec",  128'(busy_vec),  128'(e.bv));
        chk("err",       128'(err),       128'(e.er));
      end
    end
  end

  function automatic logic [D-1:0] pack_busy();
    logic [D-1:0] v;
    for (int k = 0; k < D; k++) v[k] = m_busy[k];
    return v;
  endfunction

  // One clock of stimulus; called just after a rising edge.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic wbe, input logic [AW-1:0] wba, input logic [DW-1:0] wbd,
                      input logic rse, input logic [AW-1:0] rsa, input logic [NR*AW-1:0] ra);
    logic [DW-1:0] nr [D];
    logic          nb [D];
    logic          ne;
    logic          rr;
    logic [AW-1:0] a;
    exp_t          e;
    write_enable = we;  write_addr = wa;  write_data = wd;
    wb_enable    = wbe; wb_addr    = wba; wb_data    = wbd;
    rsv_enable   = rse; rsv_addr   = rsa; read_addr  = ra;
    nr = m_regs; nb = m_busy; ne = m_err;
    rr = !m_busy[rsa] || (wbe && wba == rsa);
    if (wbe && wba != 0) begin
      nr[wba] = wbd;
      nb[wba] = 1'b0;
      if (!m_busy[wba]) ne = 1'b1;
    end
    if (we && wa != 0) begin
      if (m_busy[wa] || (wbe && wba == wa)) ne = 1'b1;
      else nr[wa] = wd;
    end
    if (rse && rr && rsa != 0) nb[rsa] = 1'b1;
    // With forwarding, a read sees what the register will hold after the edge.
    for (int i = 0; i < NR; i++) begin
      a = ra[i*AW +: AW];
      e.rd[i*DW +: DW] = (a == 0) ? '0 : nr[a];
      e.rb[i] = (a == 0 || (wbe && wba == a)) ? 1'b0 : m_busy[a];
    end
    e.rr = rr;
    e.bv = pack_busy();
    e.er = m_err;
    q.push_back(e);
    @(posedge clk);
    m_regs = nr; m_busy = nb; m_err = ne;
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    write_enable = 1'b0; wb_enable = 1'b0; rsv_enable = 1'b0;
    read_addr = NR*AW'($urandom);
    #1 rst = 1'b1;
    for (int k = 0; k < D; k++) begin m_regs[k] = '0; m_busy[k] = 1'b0; end
    m_err = 1'b0;
    e.rd = '0; e.rb = '0; e.rr = 1'b1; e.bv = '0; e.er = 1'b0;
    q.push_back(e);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [NR*AW-1:0] all4(input logic [AW-1:0] a);
    return {a, a, a, a};
  endfunction

  function automatic logic [AW-1:0] raddr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
  endfunction

  initial begin : stim
    int guard;
    for (int k = 0; k < D; k++) begin m_regs[k] = '0; m_busy[k] = 1'b0; end
    m_err = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // basic write with same-cycle forwarding, then registered read
    step(1, 15, 15, 0, 0, 0, 0, 0, {5'd1, 5'd2, 5'd0, 5'd15});
    step(0, 0, 0, 0, 0, 0, 0, 0, all4(15));
    // zero register
    step(1, 0, 123, 0, 0, 0, 0, 0, all4(0));
    step(0, 0, 0, 0, 0, 0, 1, 0, all4(0));
    step(0, 0, 0, 0, 0, 0, 0, 0, all4(0));
    // reserve 3, observe busy, second reserve refused
    step(0, 0, 0, 0, 0, 0, 1, 3, all4(3));
    step(0, 0, 0, 0, 0, 0, 1, 3, all4(3));
    step(0, 0, 0, 1, 3, 32'hDEADBEEF, 0, 0, all4(3));
    step(0, 0, 0, 0, 0, 0, 0, 0, all4(3));
    // execute write to busy register is dropped and flags err
    step(0, 0, 0, 0, 0, 0, 1, 3, all4(3));
    step(1, 3, 32'h11111111, 0, 0, 0, 0, 0, all4(3));
    step(0, 0, 0, 0, 0, 0, 0, 0, all4(3));
    step(0, 0, 0, 0, 0, 0, 0, 0, all4(3));
    do_reset();
    // writeback to non-busy register
    step(0, 0, 0, 1, 7, 32'hCAFEF00D, 0, 0, all4(7));
    step(0, 0, 0, 0, 0, 0, 0, 0, all4(7));
    do_reset();
    // simultaneous reserve and writeback on a busy register
    step(0, 0, 0, 0, 0, 0, 1, 5, all4(5));
    step(0, 0, 0, 1, 5, 32'h5A5A5A5A, 1, 5, all4(5));
    step(0, 0, 0, 0, 0, 0, 0, 0, all4(5));
    // simultaneous execute and writeback to the same register
    do_reset();
    step(0, 0, 0, 0, 0, 0, 1, 6, all4(6));
    step(1, 6, 32'h1, 1, 6, 32'h2, 0, 0, all4(6));
    step(0, 0, 0, 0, 0, 0, 0, 0, all4(6));

    for (int n = 0; n < 800; n++) begin
      if (n % 60 == 59) do_reset();
      else step($urandom_range(0, 1) == 0, raddr(), $urandom,
                $urandom_range(0, 2) == 0, raddr(), $urandom,
                $urandom_range(0, 4) < 2, raddr(),
                {raddr(), raddr(), raddr(), raddr()});
    end

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(negedge clk); #1;
      guard++;
    end
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
